// File: rtl/hub75_pkg.sv
// Shared types and width helpers for the HUB75 binary-code-modulation scheduler.
package hub75_pkg;

  localparam int DEF_BPP      = 8;
  localparam int DEF_ROWS     = 16;
  localparam int DEF_BASE_W   = 16;
  localparam int DEF_BRIGHT_W = 8;

  // Pointer fields are sized for up to 256 rows and 32 bit-planes.
  localparam int PTR_ROW_W = 8;
  localparam int PTR_BIT_W = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    LATCH     = 3'd2,
    ON        = 3'd3,
    BLANK     = 3'd4
  } state_t;

  typedef struct packed {
    logic [PTR_ROW_W-1:0] row;
    logic [PTR_BIT_W-1:0] bit_idx;
  } plane_ptr_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int base_w, input int bpp);
    return base_w + bpp;
  endfunction

endpackage

// File: rtl/hub75_ontime_calc.sv
// On-time of one bit-plane: (base << bit) scaled by (brightness+1)/2^BRIGHT_W.
module hub75_ontime_calc
  import hub75_pkg::*;
#(
  parameter int BPP      = DEF_BPP,
  parameter int BASE_W   = DEF_BASE_W,
  parameter int BRIGHT_W = DEF_BRIGHT_W,
  parameter int BIT_W    = idx_w(DEF_BPP)
) (
  input  logic [BASE_W-1:0]     base_wait,
  input  logic [BIT_W-1:0]      bit_idx,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [BASE_W+BPP-1:0] on_time
);

  localparam int FULL_W = BASE_W + BPP + BRIGHT_W + 1;
  localparam int OUT_W  = BASE_W + BPP;

  logic [FULL_W-1:0] shifted_s;
  logic [FULL_W-1:0] scale_s;
  logic [FULL_W-1:0] product_s;

  // Full-width product so no intermediate overflow before the final truncation.
  always_comb begin
    shifted_s = FULL_W'(base_wait) << bit_idx;
    scale_s   = FULL_W'(brightness) + FULL_W'(1);
    product_s = shifted_s * scale_s;
    on_time   = OUT_W'(product_s >> BRIGHT_W);
  end

endmodule

// File: rtl/hub75_bcm_scheduler.sv
// BCM scheduler: sequences bit-planes across rows, drives OE_n/LAT/address and
// prefetches the next plane from the shift engine while the current one shows.
module hub75_bcm_scheduler
  import hub75_pkg::*;
#(
  parameter int BPP      = DEF_BPP,
  parameter int ROWS     = DEF_ROWS,
  parameter int BASE_W   = DEF_BASE_W,
  parameter int BRIGHT_W = DEF_BRIGHT_W,
  localparam int ROW_W   = idx_w(ROWS),
  localparam int BIT_W   = idx_w(BPP),
  localparam int CNT_W   = cnt_w(BASE_W, BPP)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic [BASE_W-1:0]   i_base_wait,
  input  logic [BASE_W-1:0]   i_blank_interval,
  input  logic [BRIGHT_W-1:0] i_brightness,
  output logic                o_load_req,
  output logic [ROW_W-1:0]    o_load_row,
  output logic [BIT_W-1:0]    o_load_bit,
  input  logic                i_load_done,
  output logic                o_lat,
  output logic                o_oe_n,
  output logic [ROW_W-1:0]    o_row_addr,
  output logic [BIT_W-1:0]    o_bit,
  output logic                o_frame_start
);

  localparam plane_ptr_t PTR_ZERO = '{row: {PTR_ROW_W{1'b0}}, bit_idx: {PTR_BIT_W{1'b0}}};

  state_t           state_r;
  plane_ptr_t       nxt_r;
  logic             loaded_r;
  logic             pend_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] on_r;
  logic [BASE_W-1:0] blank_r;

  plane_ptr_t       adv_s;
  logic [CNT_W-1:0] on_calc_s;
  logic [CNT_W-1:0] on_last_s;
  logic [CNT_W-1:0] blank_last_s;
  logic             done_ok_s;
  logic             have_plane_s;
  logic             go_latch_s;

  hub75_ontime_calc #(
    .BPP      (BPP),
    .BASE_W   (BASE_W),
    .BRIGHT_W (BRIGHT_W),
    .BIT_W    (BIT_W)
  ) u_ontime (
    .base_wait  (i_base_wait),
    .bit_idx    (BIT_W'(nxt_r.bit_idx)),
    .brightness (i_brightness),
    .on_time    (on_calc_s)
  );

  // Next-plane pointer advance, done qualification and LATCH entry decision.
  always_comb begin
    adv_s = nxt_r;
    if (nxt_r.bit_idx == PTR_BIT_W'(BPP - 1)) begin
      adv_s.bit_idx = {PTR_BIT_W{1'b0}};
      if (nxt_r.row == PTR_ROW_W'(ROWS - 1)) begin
        adv_s.row = {PTR_ROW_W{1'b0}};
      end else begin
        adv_s.row = nxt_r.row + PTR_ROW_W'(1);
      end
    end else begin
      adv_s.bit_idx = nxt_r.bit_idx + PTR_BIT_W'(1);
    end

    done_ok_s    = i_load_done & pend_r;
    have_plane_s = loaded_r | done_ok_s;
    on_last_s    = on_r - CNT_W'(1);
    blank_last_s = CNT_W'(blank_r) - CNT_W'(1);

    go_latch_s = 1'b0;
    case (state_r)
      WAIT_DATA: go_latch_s = have_plane_s;
      BLANK:     go_latch_s = have_plane_s && (cnt_r == blank_last_s);
      default:   go_latch_s = 1'b0;
    endcase
  end

  // Scheduler FSM; outputs are registered so each reflects the state it enters.
  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      state_r       <= IDLE;
      nxt_r         <= PTR_ZERO;
      loaded_r      <= 1'b0;
      pend_r        <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
      on_r          <= {CNT_W{1'b0}};
      blank_r       <= BASE_W'(1);
      o_load_req    <= 1'b0;
      o_load_row    <= {ROW_W{1'b0}};
      o_load_bit    <= {BIT_W{1'b0}};
      o_lat         <= 1'b0;
      o_oe_n        <= 1'b1;
      o_row_addr    <= {ROW_W{1'b0}};
      o_bit         <= {BIT_W{1'b0}};
      o_frame_start <= 1'b0;
    end else begin
      o_load_req    <= 1'b0;
      o_lat         <= 1'b0;
      o_frame_start <= 1'b0;
      if (done_ok_s) begin
        pend_r   <= 1'b0;
        loaded_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          state_r    <= WAIT_DATA;
          cnt_r      <= {CNT_W{1'b0}};
          pend_r     <= 1'b1;
          o_load_req <= 1'b1;
          o_load_row <= ROW_W'(nxt_r.row);
          o_load_bit <= BIT_W'(nxt_r.bit_idx);
        end
        WAIT_DATA: begin
          o_oe_n <= 1'b1;
        end
        LATCH: begin
          cnt_r <= {CNT_W{1'b0}};
          if (on_r != {CNT_W{1'b0}}) begin
            state_r <= ON;
            o_oe_n  <= 1'b0;
          end else begin
            state_r <= BLANK;
            o_oe_n  <= 1'b1;
          end
        end
        ON: begin
          if (cnt_r == on_last_s) begin
            state_r <= BLANK;
            o_oe_n  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        BLANK: begin
          if (cnt_r == blank_last_s) begin
            state_r <= WAIT_DATA;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          o_oe_n  <= 1'b1;
        end
      endcase

      // Latch the loaded plane, shadow its timing and prefetch the following one.
      if (go_latch_s) begin
        state_r       <= LATCH;
        cnt_r         <= {CNT_W{1'b0}};
        o_lat         <= 1'b1;
        o_oe_n        <= 1'b1;
        o_row_addr    <= ROW_W'(nxt_r.row);
        o_bit         <= BIT_W'(nxt_r.bit_idx);
        o_frame_start <= (nxt_r == PTR_ZERO);
        on_r          <= on_calc_s;
        blank_r       <= (i_blank_interval == {BASE_W{1'b0}}) ? BASE_W'(1) : i_blank_interval;
        nxt_r         <= adv_s;
        loaded_r      <= 1'b0;
        pend_r        <= 1'b1;
        o_load_req    <= 1'b1;
        o_load_row    <= ROW_W'(adv_s.row);
        o_load_bit    <= BIT_W'(adv_s.bit_idx);
      end
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Directed bench for hub75_bcm_scheduler with BPP=4, ROWS=2 and a shift-engine responder.
module tb_hub75_bcm_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic [15:0] i_base_wait;
  logic [15:0] i_blank_interval;
  logic [7:0]  i_brightness;
  logic        i_load_done;
  logic        o_load_req;
  logic [0:0]  o_load_row;
  logic [1:0]  o_load_bit;
  logic        o_lat;
  logic        o_oe_n;
  logic [0:0]  o_row_addr;
  logic [1:0]  o_bit;
  logic        o_frame_start;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic resp_done  = 1'b0;
  logic stray_done = 1'b0;
  int   resp_cd    = 0;
  bit   long_bit3  = 1'b0;
  int   done_cyc   = 0;

  bit         mon_en     = 1'b0;
  int         bad_lat_oe = 0;
  int         bad_row    = 0;
  int         bad_fs     = 0;
  logic [0:0] prev_row   = 1'b0;

  int low255 [4];
  int low127 [4];
  int low_zero [4];
  int r0;
  int ev;

  hub75_bcm_scheduler #(
    .BPP      (4),
    .ROWS     (2),
    .BASE_W   (16),
    .BRIGHT_W (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_en             (i_en),
    .i_base_wait      (i_base_wait),
    .i_blank_interval (i_blank_interval),
    .i_brightness     (i_brightness),
    .o_load_req       (o_load_req),
    .o_load_row       (o_load_row),
    .o_load_bit       (o_load_bit),
    .i_load_done      (i_load_done),
    .o_lat            (o_lat),
    .o_oe_n           (o_oe_n),
    .o_row_addr       (o_row_addr),
    .o_bit            (o_bit),
    .o_frame_start    (o_frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  assign i_load_done = resp_done | stray_done;

  // Shift engine model: one-cycle done a fixed delay after each request.
  always @(negedge clk) begin
    resp_done = 1'b0;
    if (rst || !i_en) begin
      resp_cd = 0;
    end else begin
      if (resp_cd > 0) begin
        resp_cd--;
        if (resp_cd == 0) begin
          resp_done = 1'b1;
          done_cyc  = cyc;
        end
      end
      if (o_load_req === 1'b1) resp_cd = (long_bit3 && o_load_bit == 2'd3) ? 40 : 2;
    end
  end

  // Continuous panel-protocol watch while the scheduler runs undisturbed.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_lat === 1'b1 && o_oe_n === 1'b0) bad_lat_oe++;
      if (o_row_addr !== prev_row && o_lat !== 1'b1) bad_row++;
      if (o_frame_start === 1'b1 && o_lat !== 1'b1) bad_fs++;
    end
    prev_row = o_row_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_lat(input string tag);
    int n = 0;
    while (o_lat !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, o_lat}, 32'd1);
  endtask

  // Called at a LAT cycle: checks the latched plane, the prefetch, then OE runs up to the next LAT.
  task automatic plane(input int r, input int b, input int exp_low, input int exp_high);
    int nb = (b == 3) ? 0 : b + 1;
    int nr = (b == 3) ? ((r == 1) ? 0 : r + 1) : r;
    int low = 0;
    int high = 0;
    int n = 0;
    check("row_addr", {31'd0, o_row_addr}, r);
    check("bit", {30'd0, o_bit}, b);
    check("frame_start", {31'd0, o_frame_start}, (r == 0 && b == 0) ? 1 : 0);
    check("prefetch_req", {31'd0, o_load_req}, 1);
    check("prefetch_row", {31'd0, o_load_row}, nr);
    check("prefetch_bit", {30'd0, o_load_bit}, nb);
    @(negedge clk);
    while (o_lat !== 1'b1 && n < 400) begin
      if (o_oe_n === 1'b0) low++;
      else high++;
      @(negedge clk);
      n++;
    end
    check("next_lat", {31'd0, o_lat}, 1);
    check("oe_low_run", low, exp_low);
    check("oe_high_run", high, exp_high);
  endtask

  task automatic enable_and_sync();
    i_en = 1'b1;
    @(negedge clk);
    check("req_after_en", {31'd0, o_load_req}, 1);
    check("req_row0", {31'd0, o_load_row}, 0);
    check("req_bit0", {30'd0, o_load_bit}, 0);
    r0 = cyc;
    wait_lat("first_lat");
    check("first_lat_latency", cyc - r0, 3);
    mon_en = 1'b1;
  endtask

  task automatic restart(input int br, input int base);
    mon_en = 1'b0;
    i_en = 1'b0;
    repeat (3) @(negedge clk);
    i_brightness = 8'(br);
    i_base_wait  = 16'(base);
    enable_and_sync();
  endtask

  initial begin
    low255   = '{2, 4, 8, 16};
    low127   = '{1, 2, 4, 8};
    low_zero = '{0, 0, 0, 0};
    rst = 1'b1;
    i_en = 1'b0;
    i_base_wait = 16'd2;
    i_blank_interval = 16'd3;
    i_brightness = 8'd255;
    repeat (3) @(negedge clk);
    check("rst_oe_n", {31'd0, o_oe_n}, 1);
    check("rst_lat", {31'd0, o_lat}, 0);
    check("rst_load_req", {31'd0, o_load_req}, 0);
    check("rst_row", {31'd0, o_row_addr}, 0);
    check("rst_bit", {30'd0, o_bit}, 0);
    check("rst_fs", {31'd0, o_frame_start}, 0);
    rst = 1'b0;
    @(negedge clk);
    enable_and_sync();

    // Full brightness, two frames (second covers wrap back to row 0).
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 2; r++)
        for (int b = 0; b < 4; b++) plane(r, b, low255[b], 3);

    restart(127, 2);
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 4; b++) plane(r, b, low127[b], 3);

    restart(0, 2);
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 4; b++) plane(r, b, low_zero[b], 3);

    restart(255, 0);
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 4; b++) plane(r, b, low_zero[b], 3);

    // Slow load of bit 3: display stalls in WAIT_DATA until done, LAT the cycle after.
    long_bit3 = 1'b1;
    restart(255, 2);
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 3) check("lat_after_done", cyc - done_cyc, 1);
        plane(r, b, low255[b], (b == 2) ? 32 : 3);
      end
    end
    long_bit3 = 1'b0;

    // Disable mid-ON of bit 2, then a stray done while idle.
    restart(255, 2);
    plane(0, 0, 2, 3);
    plane(0, 1, 4, 3);
    repeat (3) @(negedge clk);
    check("mid_on_oe", {31'd0, o_oe_n}, 0);
    mon_en = 1'b0;
    i_en = 1'b0;
    @(negedge clk);
    check("dis_oe_n", {31'd0, o_oe_n}, 1);
    check("dis_lat", {31'd0, o_lat}, 0);
    check("dis_req", {31'd0, o_load_req}, 0);
    check("dis_row", {31'd0, o_row_addr}, 0);
    check("dis_bit", {30'd0, o_bit}, 0);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    ev = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_lat !== 1'b0 || o_oe_n !== 1'b1 || o_load_req !== 1'b0) ev++;
    end
    check("idle_quiet", ev, 0);
    enable_and_sync();

    // Synchronous reset mid-BLANK of plane (0,0).
    repeat (4) @(negedge clk);
    check("mid_blank_oe", {31'd0, o_oe_n}, 1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("srst_oe_n", {31'd0, o_oe_n}, 1);
    check("srst_lat", {31'd0, o_lat}, 0);
    check("srst_req", {31'd0, o_load_req}, 0);
    check("srst_bit", {30'd0, o_bit}, 0);
    rst = 1'b0;
    enable_and_sync();
    plane(0, 0, 2, 3);

    check("lat_with_oe_low", bad_lat_oe, 0);
    check("row_change_outside_lat", bad_row, 0);
    check("frame_start_outside_lat", bad_fs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
